bch_ecc_stream_encoder: RTL
===========================

# bch_ecc_stream_encoder

Multi-channel, multi-bit-per-clock BCH ECC encoder for HDMI data island packets. It replaces the one-bit-per-clock header encoder with a single parametrised block. It sequences each packet itself: it passes data bits through, then emits the 8 parity bits per channel, with no external data gating. One instance (1 channel × 1 bit/clock × 24 bits) serves the packet header. A second instance (4 channels × 2 bits/clock × 56 bits) serves the four subpackets. Both sit between the packet assembler and the TERC4 channel mapper.

## Interface
- CHANNELS, 4, number of independent BCH codewords encoded in parallel (1..4)
- BITS_PER_CLOCK, 2, codeword bits consumed/emitted per channel per clock (1 or 2)
- DATA_BITS, 56, data bits per codeword (24 header, 56 subpacket); must be divisible by BITS_PER_CLOCK
- clock  in  1  pixel clock; single clock domain
- reset  in  1  synchronous, active-high reset
- start  in  1  high on the clock carrying the first data bits of a packet
- data_in  in  CHANNELS*BITS_PER_CLOCK  data bits; channel c occupies [c*BPC +: BPC]; lower index = earlier bit
- data_out  out  CHANNELS*BITS_PER_CLOCK  registered codeword bits (data, then parity), same lane layout
- parity_phase  out  1  high while data_out carries parity bits
- busy  out  1  high while a packet is being output
- last  out  1  high with the final parity bits of a packet

## Operation
- Derived constants: D = DATA_BITS/BPC data clocks, P = 8/BPC parity clocks, N = D+P (32 for both standard configurations).
- Per-channel ECC state: 8-bit register. One bit step: fb = bit ^ ecc[0]; ecc' = (ecc >> 1) ^ (fb ? 8'h83 : 8'h00). Generator is x^8+x^7+x^6+1.
  - With BPC=2, two steps are chained per clock, lane bit 0 first.
- Counter k (0..N-1) states: IDLE, DATA (k<D), PARITY (D≤k<N).
- start in any state:
  - Clears all ECC state, treating the current data_in as the first step from 8'h00.
  - Sets k=1 and enters DATA.
  - A start during DATA or PARITY aborts the current packet; no parity is emitted for it.
- DATA:
  - data_out ← data_in.
  - ECC advances BPC steps.
  - At k=D−1 the next state is PARITY.
- PARITY:
  - data_out lane ← ecc[BPC-1:0], so parity goes LSB first.
  - ECC shifts right by BPC with zero fill; no feedback.
  - data_in is ignored.
  - At k=N−1 the next state is IDLE, unless start is asserted.
- IDLE: data_out ← 0, ECC holds, all flags low.
- Back-to-back packets: start on the clock after the last parity clock is legal and produces gapless output.
- reset: forces IDLE, ECC=0, k=0, and all outputs 0 on the next edge. This holds mid-packet too. reset overrides start.

## Timing
- Latency is 1 clock. data_out at clock t+1 reflects the input/state at clock t.
- For start at clock t:
  - data_out at t+1..t+D equals data_in at t..t+D−1.
  - Parity appears at t+D+1..t+N.
  - last is high at t+N.
  - busy is high at t+1..t+N.
  - parity_phase is high at t+D+1..t+N.
- Reset values: data_out=0, parity_phase=0, busy=0, last=0.

## Structure
- Shared package `bch_ecc_pkg`: BCH_POLY = 8'h83, ECC_WIDTH = 8, and the single-step function.
- Sub-module `bch_ecc_lane`: one channel, chaining BPC steps, with ECC register, clear and shift-mode inputs.
  - The top instantiates CHANNELS lanes and one shared counter/FSM.
- Elaboration-time check: BPC ∈ {1,2}, and DATA_BITS % BPC == 0.

## Test plan
- Header config (1,1,24): start with bit0=1 and the remaining 23 bits 0.
  - Required: data passthrough, then ECC 8'h4A, parity bits in order 0,1,0,1,0,0,1,0.
  - last is high at clock 32 after start.
- Header config, all-zero header (null packet): 24 zero data bits, then 8 zero parity bits; busy for exactly 32 clocks.
- Subpacket config (4,2,56):
  - Channel 0 carries the same pattern as the first test padded to 56 bits; channels 1–3 carry random data.
  - Every lane matches the bit-serial reference model.
  - Parity occupies clocks 29–32 after start.
- Back-to-back: second start on the clock after last.
  - Output is continuous, the second packet's ECC is independent of the first, and busy never drops.
- Abort: a start at k=10 restarts the sequence; no parity is emitted for the aborted packet and last follows the new timing only.
- Reset mid-PARITY: all outputs are 0 on the next clock. A subsequent start produces the correct ECC (state fully cleared).

Source files
------------

// File: rtl/bch_ecc_pkg.sv
// -----------------------------------------------------------------------------
// bch_ecc_pkg
// Shared definitions for the HDMI data-island BCH ECC stream encoder.
//   BCH_POLY  : feedback mask for generator x^8+x^7+x^6+1, applied in the
//               LSB-first (right-shifting) register form.
//   ECC_WIDTH : parity bits per codeword.
//   enc_state_e : sequencing states of the encoder, exported for debug.
//   bch_step()  : one serial BCH step (one data bit into the ECC register).
// -----------------------------------------------------------------------------
package bch_ecc_pkg;

  localparam int              ECC_WIDTH = 8;
  localparam logic [ECC_WIDTH-1:0] BCH_POLY  = 8'h83;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DATA   = 2'd1,
    ST_PARITY = 2'd2
  } enc_state_e;

  // One bit step: feedback is the incoming bit XOR the bit about to leave.
  function automatic logic [ECC_WIDTH-1:0] bch_step(
    input logic [ECC_WIDTH-1:0] ecc,
    input logic                 bit_in
  );
    logic fb;
    fb = bit_in ^ ecc[0];
    return (ecc >> 1) ^ (fb ? BCH_POLY : {ECC_WIDTH{1'b0}});
  endfunction

endpackage

// File: rtl/bch_ecc_lane.sv
// -----------------------------------------------------------------------------
// bch_ecc_lane
// ECC register for one channel. Consumes BPC data bits per clock (lane bit 0
// first) or, in parity mode, shifts the register right by BPC so the caller
// can emit its low BPC bits as parity, LSB first.
// Ports:
//   clk, rst   : clock, synchronous active-high reset (clears the register)
//   clear      : restart from 8'h00 and absorb bits_in as the first step(s)
//   step       : absorb bits_in into the current register
//   shift      : parity mode, zero-fill right shift by BPC, no feedback
//   bits_in    : this channel's data bits for the clock
//   ecc        : current register contents
// Priority: clear > step > shift; with none asserted the register holds.
// -----------------------------------------------------------------------------
module bch_ecc_lane
  import bch_ecc_pkg::*;
#(
  parameter int BPC = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clear,
  input  logic                 step,
  input  logic                 shift,
  input  logic [BPC-1:0]       bits_in,
  output logic [ECC_WIDTH-1:0] ecc
);

  logic [ECC_WIDTH-1:0] ecc_q;
  logic [ECC_WIDTH-1:0] ecc_d;
  logic [ECC_WIDTH-1:0] stepped;

  always_comb begin
    // Start from zero on clear so the first data bits of a new packet never
    // see state from an aborted or previous packet.
    stepped = clear ? {ECC_WIDTH{1'b0}} : ecc_q;
    for (int i = 0; i < BPC; i++) begin
      stepped = bch_step(stepped, bits_in[i]);
    end

    ecc_d = ecc_q;
    if (clear || step) begin
      ecc_d = stepped;
    end else if (shift) begin
      ecc_d = ecc_q >> BPC;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ecc_q <= '0;
    end else begin
      ecc_q <= ecc_d;
    end
  end

  assign ecc = ecc_q;

endmodule

// File: rtl/bch_ecc_stream_encoder.sv
// -----------------------------------------------------------------------------
// bch_ecc_stream_encoder
// Multi-channel BCH ECC encoder for HDMI data-island packets. For each packet
// it passes D clocks of data straight through, then emits P clocks of parity
// per channel, sequencing itself from a single start pulse.
// Ports:
//   clock, reset  : pixel clock, synchronous active-high reset
//   start         : first data clock of a packet (aborts any packet in flight)
//   data_in       : CHANNELS*BPC data bits, channel c at [c*BPC +: BPC],
//                   lower index = earlier bit
//   data_out      : registered codeword bits, same lane layout
//   parity_phase  : data_out carries parity
//   busy          : a packet is on data_out
//   last          : data_out carries the final parity bits
//   dbg_state     : current sequencing state (enc_state_e encoding)
// All outputs are registered: output at clock t+1 reflects inputs/state at t.
// There is no backpressure; the stream is a fixed-rate pipeline.
// -----------------------------------------------------------------------------
module bch_ecc_stream_encoder
  import bch_ecc_pkg::*;
#(
  parameter int CHANNELS       = 4,
  parameter int BITS_PER_CLOCK = 2,
  parameter int DATA_BITS      = 56
) (
  input  logic                               clock,
  input  logic                               reset,
  input  logic                               start,
  input  logic [CHANNELS*BITS_PER_CLOCK-1:0] data_in,
  output logic [CHANNELS*BITS_PER_CLOCK-1:0] data_out,
  output logic                               parity_phase,
  output logic                               busy,
  output logic                               last,
  output logic [1:0]                         dbg_state
);

  localparam int BPC = BITS_PER_CLOCK;
  localparam int LW  = CHANNELS * BPC;
  localparam int D   = DATA_BITS / BPC;
  localparam int P   = ECC_WIDTH / BPC;
  localparam int N   = D + P;
  localparam int K_W = (N > 2) ? $clog2(N) : 1;

  localparam logic [K_W-1:0] K_D_LAST = K_W'(D - 1);
  localparam logic [K_W-1:0] K_N_LAST = K_W'(N - 1);

  if (BPC < 1 || BPC > 2) begin : g_bad_bpc
    $error("bch_ecc_stream_encoder: BITS_PER_CLOCK must be 1 or 2");
  end
  if ((DATA_BITS % BPC) != 0) begin : g_bad_data_bits
    $error("bch_ecc_stream_encoder: DATA_BITS must be divisible by BITS_PER_CLOCK");
  end
  if (CHANNELS < 1 || CHANNELS > 4) begin : g_bad_channels
    $error("bch_ecc_stream_encoder: CHANNELS must be 1..4");
  end

  enc_state_e           state_q, state_d;
  logic [K_W-1:0]       k_q, k_d;
  logic [LW-1:0]        data_out_q, data_out_d;
  logic                 parity_phase_q, parity_phase_d;
  logic                 busy_q, busy_d;
  logic                 last_q, last_d;

  logic                 lane_clear;
  logic                 lane_step;
  logic                 lane_shift;
  logic [ECC_WIDTH-1:0] lane_ecc [CHANNELS];

  for (genvar c = 0; c < CHANNELS; c++) begin : g_lane
    bch_ecc_lane #(
      .BPC (BPC)
    ) u_lane (
      .clk     (clock),
      .rst     (reset),
      .clear   (lane_clear),
      .step    (lane_step),
      .shift   (lane_shift),
      .bits_in (data_in[c*BPC +: BPC]),
      .ecc     (lane_ecc[c])
    );
  end

  always_comb begin
    state_d        = state_q;
    k_d            = k_q;
    data_out_d     = '0;
    parity_phase_d = 1'b0;
    busy_d         = 1'b0;
    last_d         = 1'b0;
    lane_clear     = 1'b0;
    lane_step      = 1'b0;
    lane_shift     = 1'b0;

    if (start) begin
      // start wins in every state; the clock carrying it is data clock 0.
      lane_clear = 1'b1;
      data_out_d = data_in;
      busy_d     = 1'b1;
      k_d        = K_W'(1);
      state_d    = (K_D_LAST == '0) ? ST_PARITY : ST_DATA;
    end else begin
      case (state_q)
        ST_DATA: begin
          lane_step  = 1'b1;
          data_out_d = data_in;
          busy_d     = 1'b1;
          k_d        = k_q + K_W'(1);
          if (k_q == K_D_LAST) begin
            state_d = ST_PARITY;
          end
        end
        ST_PARITY: begin
          // Parity leaves LSB first; the lane shifts the emitted bits out.
          lane_shift = 1'b1;
          for (int c = 0; c < CHANNELS; c++) begin
            data_out_d[c*BPC +: BPC] = lane_ecc[c][BPC-1:0];
          end
          parity_phase_d = 1'b1;
          busy_d         = 1'b1;
          if (k_q == K_N_LAST) begin
            last_d  = 1'b1;
            k_d     = '0;
            state_d = ST_IDLE;
          end else begin
            k_d = k_q + K_W'(1);
          end
        end
        default: begin
          k_d     = '0;
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q        <= ST_IDLE;
      k_q            <= '0;
      data_out_q     <= '0;
      parity_phase_q <= 1'b0;
      busy_q         <= 1'b0;
      last_q         <= 1'b0;
    end else begin
      state_q        <= state_d;
      k_q            <= k_d;
      data_out_q     <= data_out_d;
      parity_phase_q <= parity_phase_d;
      busy_q         <= busy_d;
      last_q         <= last_d;
    end
  end

  assign data_out     = data_out_q;
  assign parity_phase = parity_phase_q;
  assign busy         = busy_q;
  assign last         = last_q;
  assign dbg_state    = state_q;

endmodule
